// File: rtl/chord_song_reader_if.sv
// Song-reader bus: ROM read port, chord-player strobes and play/song control.
// The reader is the master; the ROM, player and controller side is the slave.
interface chord_song_reader_if #(
  parameter int SONG_BITS  = 2,
  parameter int ADDR_WIDTH = 5
);
  logic                            play;
  logic [SONG_BITS-1:0]            song;
  logic                            activate_done;
  logic [15:0]                     rom_data;
  logic [SONG_BITS+ADDR_WIDTH-1:0] rom_addr;
  logic [5:0]                      note_to_load;
  logic [5:0]                      duration;
  logic                            load_new_note;
  logic                            activate;
  logic                            song_done;

  modport master (
    input  play, song, activate_done, rom_data,
    output rom_addr, note_to_load, duration, load_new_note, activate, song_done
  );

  modport slave (
    output play, song, activate_done, rom_data,
    input  rom_addr, note_to_load, duration, load_new_note, activate, song_done
  );
endinterface

// File: rtl/chord_song_reader.sv
// Walks a song in synchronous ROM, issuing notes to the chord player and
// stalling on advance entries until the player's advance timer expires.
module chord_song_reader #(
  parameter int SONG_BITS  = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  chord_song_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_ADV,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [SONG_BITS-1:0]  r_song;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [5:0]            r_note;
  logic [5:0]            r_dur;
  logic                  r_is_adv;

  logic w_end;
  logic w_adv;
  logic w_dur_zero;
  logic w_last;
  logic w_issue;

  assign w_end      = (bus.rom_data == 16'h0000);
  assign w_adv      = bus.rom_data[15];
  assign w_dur_zero = (bus.rom_data[8:3] == 6'd0);
  assign w_last     = &r_addr;

  // Every state except IDLE/DONE freezes completely while play is low; the
  // ROM address is held, so DECODE sees the same entry again on resume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_song   <= '0;
      r_addr   <= '0;
      r_note   <= '0;
      r_dur    <= '0;
      r_is_adv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.play) begin
            r_song  <= bus.song;
            r_addr  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.play) r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (bus.play) begin
            if (w_end) begin
              r_state <= S_DONE;
            end else if (w_adv && w_dur_zero) begin
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_addr  <= r_addr + ADDR_ONE;
                r_state <= S_FETCH;
              end
            end else begin
              r_note   <= bus.rom_data[14:9];
              r_dur    <= bus.rom_data[8:3];
              r_is_adv <= w_adv;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.play) begin
            if (r_is_adv) begin
              r_state <= S_WAIT_LOW;
            end else if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + ADDR_ONE;
              r_state <= S_FETCH;
            end
          end
        end
        S_WAIT_LOW: begin
          // One cycle for the player to load its counter before done is trusted.
          if (bus.play) r_state <= S_WAIT_ADV;
        end
        S_WAIT_ADV: begin
          if (bus.play && bus.activate_done) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + ADDR_ONE;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (!bus.play) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == S_ISSUE);

  assign bus.rom_addr      = {r_song, r_addr};
  assign bus.note_to_load  = r_note;
  assign bus.duration      = r_dur;
  assign bus.load_new_note = w_issue & bus.play;
  assign bus.activate      = w_issue & bus.play & r_is_adv;
  assign bus.song_done     = (r_state == S_DONE);

endmodule
